// File: rtl/umi_req_arb.sv
// Round-robin N:1 arbiter for UMI request beats with packet lock until EOM; 1-cycle registered output.
// Backpressure: a new beat loads only when the output register is empty or draining (valid-ready).
module umi_req_arb #(
  parameter int N      = 5,
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int DW     = 256,
  parameter int EOMBIT = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]    uhost_req_valid,
  input  logic [N*CW-1:0] uhost_req_cmd,
  input  logic [N*AW-1:0] uhost_req_dstaddr,
  input  logic [N*AW-1:0] uhost_req_srcaddr,
  input  logic [N*DW-1:0] uhost_req_data,
  output logic [N-1:0]    uhost_req_ready,
  output logic          udev_req_valid,
  output logic [CW-1:0] udev_req_cmd,
  output logic [AW-1:0] udev_req_dstaddr,
  output logic [AW-1:0] udev_req_srcaddr,
  output logic [DW-1:0] udev_req_data,
  output logic [N-1:0]  udev_req_sel,
  input  logic          udev_req_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] lock_port;
  logic          lock;
  logic [N-1:0]  grant;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] ptr_next;
  logic          load_en;
  logic          acc;
  logic          found;
  int            idx;
  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dst;
  logic [AW-1:0] sel_src;
  logic [DW-1:0] sel_data;

  // Locked: only the packet owner may proceed. Unlocked: first valid from ptr onward.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (lock) begin
      grant[lock_port] = uhost_req_valid[lock_port];
      gnt_idx          = lock_port;
    end else begin
      for (int off = 0; off < N; off++) begin
        idx = int'(ptr) + off;
        if (idx >= N) idx = idx - N;
        if (!found && uhost_req_valid[idx]) begin
          found        = 1'b1;
          grant[idx]   = 1'b1;
          gnt_idx      = PW'(idx);
        end
      end
    end
  end

  assign load_en         = ~udev_req_valid | udev_req_ready;
  assign acc             = load_en & (|grant);
  assign uhost_req_ready = (load_en & ~reset) ? grant : '0;
  assign ptr_next        = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  assign sel_cmd  = uhost_req_cmd[int'(gnt_idx)*CW +: CW];
  assign sel_dst  = uhost_req_dstaddr[int'(gnt_idx)*AW +: AW];
  assign sel_src  = uhost_req_srcaddr[int'(gnt_idx)*AW +: AW];
  assign sel_data = uhost_req_data[int'(gnt_idx)*DW +: DW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udev_req_valid   <= 1'b0;
      udev_req_sel     <= '0;
      udev_req_cmd     <= '0;
      udev_req_dstaddr <= '0;
      udev_req_srcaddr <= '0;
      udev_req_data    <= '0;
      ptr              <= '0;
      lock             <= 1'b0;
      lock_port        <= '0;
    end else if (load_en) begin
      if (acc) begin
        udev_req_valid   <= 1'b1;
        udev_req_sel     <= grant;
        udev_req_cmd     <= sel_cmd;
        udev_req_dstaddr <= sel_dst;
        udev_req_srcaddr <= sel_src;
        udev_req_data    <= sel_data;
        ptr              <= ptr_next;
        lock             <= ~sel_cmd[EOMBIT];
        lock_port        <= gnt_idx;
      end else begin
        udev_req_valid <= 1'b0;
      end
    end
  end

endmodule
